// File: rtl/mul_accumulator.sv
// Accumulates a run of signed 64-bit products under a valid/ready handshake.
// Define MUL_ACC_SATURATE_EN to clamp the sum on signed overflow instead of wrapping.
module mul_accumulator #(
    parameter int LEN_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_abort,
    input  logic             i_prod_valid,
    input  logic [63:0]      i_product,
    output logic             o_prod_ready,
    output logic [63:0]      o_acc_out,
    output logic             o_acc_valid,
    output logic             o_busy,
    output logic [LEN_W-1:0] o_count,
    output logic             o_overflow
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    localparam logic [63:0] SAT_POS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SAT_NEG = 64'h8000_0000_0000_0000;

    state_t           r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_count;
    logic [63:0]      r_acc;
    logic             r_ovf;
    logic             r_acc_valid;

    logic             w_hs;
    logic [63:0]      w_sum;
    logic             w_ovf;
    logic [63:0]      w_acc_nx;
    logic [LEN_W-1:0] w_cnt_nx;

    assign w_hs     = (r_state == S_ACCUM) && i_prod_valid;
    assign w_sum    = r_acc + i_product;
    // Same-sign operands producing an opposite-sign sum is a signed overflow.
    assign w_ovf    = (r_acc[63] == i_product[63]) && (w_sum[63] != r_acc[63]);
    assign w_cnt_nx = r_count + LEN_W'(1);

`ifdef MUL_ACC_SATURATE_EN
    assign w_acc_nx = w_ovf ? (r_acc[63] ? SAT_NEG : SAT_POS) : w_sum;
`else
    assign w_acc_nx = w_sum;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_count     <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_acc_valid <= 1'b0;
        end else begin
            r_acc_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_len   <= i_len;
                        r_count <= '0;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        if (i_len != '0) begin
                            r_state <= S_ACCUM;
                        end else begin
                            r_state     <= S_DONE;
                            r_acc_valid <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    // Abort wins over a same-cycle handshake; that product is dropped.
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_hs) begin
                        r_acc   <= w_acc_nx;
                        r_count <= w_cnt_nx;
                        r_ovf   <= r_ovf | w_ovf;
                        if (w_cnt_nx == r_len) begin
                            r_state     <= S_DONE;
                            r_acc_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_prod_ready = (r_state == S_ACCUM);
    assign o_busy       = (r_state == S_ACCUM);
    assign o_acc_out    = r_acc;
    assign o_acc_valid  = r_acc_valid;
    assign o_count      = r_count;
    assign o_overflow   = r_ovf;

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed and randomized checks of mul_accumulator against a wide-arithmetic model.
// Honours MUL_ACC_SATURATE_EN the same way as the design.
module tb_mul_accumulator;

    localparam int LEN_W = 8;
    localparam logic signed [64:0] MAXV = 65'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [64:0] MINV = 65'sh1_8000_0000_0000_0000;

    logic             clk = 1'b0;
    logic             rst, start, abort, prod_valid;
    logic [LEN_W-1:0] len;
    logic [63:0]      product;
    logic             prod_ready, acc_valid, busy, overflow;
    logic [63:0]      acc_out;
    logic [LEN_W-1:0] count;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_acc;
    logic        m_ovf;
    int          m_cnt;

    always #5 clk = ~clk;

    mul_accumulator #(.LEN_W(LEN_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len), .i_abort(abort),
        .i_prod_valid(prod_valid), .i_product(product), .o_prod_ready(prod_ready),
        .o_acc_out(acc_out), .o_acc_valid(acc_valid), .o_busy(busy),
        .o_count(count), .o_overflow(overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact sum in 65 bits, then wrap or clamp to the 64-bit range.
    task automatic model_add(input logic [63:0] p);
        logic signed [64:0] ex;
        ex = $signed({m_acc[63], m_acc}) + $signed({p[63], p});
        if (ex > MAXV || ex < MINV) begin
            m_ovf = 1'b1;
`ifdef MUL_ACC_SATURATE_EN
            ex = (ex > MAXV) ? MAXV : MINV;
`endif
        end
        m_acc = ex[63:0];
        m_cnt++;
    endtask

    task automatic do_start(input int n);
        start = 1'b1; len = LEN_W'(n);
        tick();
        start = 1'b0;
        m_acc = '0; m_ovf = 1'b0; m_cnt = 0;
    endtask

    task automatic handshake(input string tag, input logic [63:0] p, input int gap);
        prod_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            tick();
            chk({tag, " busy in gap"}, 64'(busy), 64'd1);
            chk({tag, " no valid in gap"}, 64'(acc_valid), 64'd0);
        end
        prod_valid = 1'b1; product = p;
        tick();
        prod_valid = 1'b0;
        model_add(p);
        chk({tag, " count"}, 64'(count), 64'(m_cnt));
        chk({tag, " acc"}, acc_out, m_acc);
    endtask

    task automatic check_done(input string tag);
        chk({tag, " acc_valid"}, 64'(acc_valid), 64'd1);
        chk({tag, " acc_out"}, acc_out, m_acc);
        chk({tag, " overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, " busy low in DONE"}, 64'(busy), 64'd0);
        tick();
        chk({tag, " single pulse"}, 64'(acc_valid), 64'd0);
        chk({tag, " idle hold"}, acc_out, m_acc);
        chk({tag, " idle ready"}, 64'(prod_ready), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; prod_valid = 1'b0;
        len = '0; product = '0;
        tick(); tick();
        chk("reset acc", acc_out, 64'd0);
        chk("reset count", 64'(count), 64'd0);
        chk("reset ovf", 64'(overflow), 64'd0);
        chk("reset ready", 64'(prod_ready), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        rst = 1'b0;
        tick();
        chk("post-reset ready", 64'(prod_ready), 64'd0);
        chk("post-reset valid", 64'(acc_valid), 64'd0);

        // Three back-to-back products.
        do_start(3);
        chk("r33 busy", 64'(busy), 64'd1);
        handshake("r33 p0", 64'd6, 0);
        handshake("r33 p1", -64'sd10, 0);
        handshake("r33 p2", 64'd100, 0);
        chk("r33 sum 96", acc_out, 64'd96);
        check_done("r33");

        // Gapped valids, negative terms.
        do_start(2);
        handshake("r34 p0", -64'sd5, 3);
        handshake("r34 p1", -64'sd7, 3);
        chk("r34 sum -12", acc_out, 64'hFFFF_FFFF_FFFF_FFF4);
        check_done("r34");

        // Positive overflow.
        do_start(2);
        handshake("r35 p0", 64'h7FFF_FFFF_FFFF_FFFF, 0);
        handshake("r35 p1", 64'd1, 0);
`ifdef MUL_ACC_SATURATE_EN
        chk("r35 clamp", acc_out, 64'h7FFF_FFFF_FFFF_FFFF);
`else
        chk("r35 wrap", acc_out, 64'h8000_0000_0000_0000);
`endif
        chk("r35 ovf", 64'(overflow), 64'd1);
        check_done("r35");

        // Zero-length run.
        do_start(0);
        chk("r36 ready", 64'(prod_ready), 64'd0);
        check_done("r36");
        chk("r36 acc zero", acc_out, 64'd0);

        // Abort with a simultaneous valid product.
        do_start(4);
        handshake("r37 p0", 64'd12, 0);
        handshake("r37 p1", 64'd3, 0);
        abort = 1'b1; prod_valid = 1'b1; product = 64'd99;
        tick();
        abort = 1'b0; prod_valid = 1'b0;
        chk("r37 idle busy", 64'(busy), 64'd0);
        chk("r37 idle ready", 64'(prod_ready), 64'd0);
        chk("r37 acc 15", acc_out, 64'd15);
        chk("r37 count 2", 64'(count), 64'd2);
        chk("r37 no valid", 64'(acc_valid), 64'd0);
        tick();
        chk("r37 still no valid", 64'(acc_valid), 64'd0);
        start = 1'b1; abort = 1'b1; len = 8'd1;
        tick();
        start = 1'b0; abort = 1'b0;
        m_acc = '0; m_ovf = 1'b0; m_cnt = 0;
        chk("r37 start+abort runs", 64'(busy), 64'd1);
        handshake("r37 p7", 64'd7, 0);
        chk("r37 acc 7", acc_out, 64'd7);
        check_done("r37b");

        // Reset mid-run.
        do_start(3);
        handshake("r38 p0", 64'd5, 0);
        rst = 1'b1; prod_valid = 1'b1; product = 64'd9;
        tick();
        prod_valid = 1'b0;
        chk("r38 acc", acc_out, 64'd0);
        chk("r38 count", 64'(count), 64'd0);
        chk("r38 busy", 64'(busy), 64'd0);
        chk("r38 valid", 64'(acc_valid), 64'd0);
        rst = 1'b0;
        tick();
        chk("r38 after ready", 64'(prod_ready), 64'd0);
        chk("r38 after valid", 64'(acc_valid), 64'd0);

        // Start while busy is ignored.
        do_start(2);
        handshake("ign p0", 64'd4, 0);
        start = 1'b1; len = 8'd9;
        tick();
        start = 1'b0;
        chk("ign count", 64'(count), 64'd1);
        chk("ign busy", 64'(busy), 64'd1);
        handshake("ign p1", 64'd6, 0);
        chk("ign acc 10", acc_out, 64'd10);
        check_done("ign");

        // Random runs, with a share of extreme products to provoke overflow.
        for (int r = 0; r < 40; r++) begin
            int n;
            n = (r % 10 == 0) ? int'($urandom_range(20, 40)) : int'($urandom_range(1, 6));
            do_start(n);
            for (int i = 0; i < n; i++) begin
                logic [63:0] p;
                case ($urandom_range(0, 3))
                    0: p = {1'b0, 63'($urandom) | 63'h7000_0000_0000_0000};
                    1: p = {1'b1, 63'($urandom)};
                    default: p = {{32{$urandom_range(0, 1) == 1}}, 32'($urandom)};
                endcase
                handshake($sformatf("rnd%0d.%0d", r, i), p, int'($urandom_range(0, 2)));
            end
            check_done($sformatf("rnd%0d", r));
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
